// File: rtl/dmem_wbuf.sv
// -----------------------------------------------------------------------------
// dmem_wbuf : data memory with a posted write buffer
//
// Stores are queued in a small circular FIFO and drained into a word RAM.
// Each RAM commit takes WR_LAT cycles. Reads are answered combinationally.
//
// Build option (macro DMEM_FWD_EN):
//   defined   : a read that hits a pending store gets the youngest matching
//               buffered data.
//   undefined : a read that hits any pending store stalls and returns 0.
//               Once the last matching entry has committed, the read is
//               served from RAM.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   mem_read_i   in   read request this cycle
//   mem_write_i  in   write request this cycle
//   mem_addr_i   in   byte address; bits [1:0] ignored
//   mem_data_i   in   store data
//   mem_data_o   out  read data (combinational; 0 when no valid read)
//   stall_o      out  request not accepted this cycle
//   wb_empty_o   out  buffer empty and drain FSM idle
//   err_o        out  sticky out-of-range access flag
// -----------------------------------------------------------------------------
module dmem_wbuf #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4,
    parameter int WR_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_o,
    output logic        wb_empty_o,
    output logic        err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(WR_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WR_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [PTR_W-1:0]  head_q,    head_d;
    logic [PTR_W-1:0]  tail_q,    tail_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              err_q,     err_d;
    logic [ADDR_W-1:0] buf_idx_q [DEPTH];
    logic [ADDR_W-1:0] buf_idx_d [DEPTH];
    logic [31:0]       buf_dat_q [DEPTH];
    logic [31:0]       buf_dat_d [DEPTH];

    // Word RAM; deliberately not reset.
    logic [31:0]       ram_mem [2**ADDR_W];

    logic [ADDR_W-1:0] word_idx_s;
    logic              in_range_s;
    logic              commit_s;
    logic              hit_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       ram_rdata_s;
    logic              unused_addr_s;
`ifdef DMEM_FWD_EN
    logic [31:0]       hit_data_s;
`endif

    assign word_idx_s    = mem_addr_i[ADDR_W+1:2];
    assign in_range_s    = ~(|mem_addr_i[31:ADDR_W+2]);
    assign unused_addr_s = ^mem_addr_i[1:0];
    assign ram_rdata_s   = ram_mem[word_idx_s];

    // The head entry is written to RAM on the edge that ends this cycle.
    assign commit_s = (state_q == ST_BUSY) && (lat_cnt_q == LAT_LAST);

    // Walk the valid entries from oldest to youngest so that the youngest match wins.
    always_comb begin
        hit_s = 1'b0;
`ifdef DMEM_FWD_EN
        hit_data_s = 32'h0000_0000;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            logic match_v;
            match_v = (CNT_W'(i) < count_q) &&
                      (buf_idx_q[head_q + PTR_W'(i)] == word_idx_s);
            hit_s   = hit_s | match_v;
`ifdef DMEM_FWD_EN
            hit_data_s = match_v ? buf_dat_q[head_q + PTR_W'(i)] : hit_data_s;
`endif
        end
    end

    // stall_o comes from the request inputs and registered state only.
    // A full buffer still accepts a store in the commit cycle, because the pop frees a slot.
    always_comb begin
        stall_o = mem_write_i && in_range_s && (count_q == CNT_FULL) && !commit_s;
`ifndef DMEM_FWD_EN
        // Without forwarding, a read that hits a pending store waits until that store commits.
        stall_o = stall_o || (mem_read_i && in_range_s && hit_s);
`endif
    end

    assign push_s = mem_write_i && in_range_s && !stall_o;
    assign pop_s  = commit_s;

    // Read data mux: buffer hit (when forwarding) or RAM; zero for no read or an invalid read.
    always_comb begin
        mem_data_o = 32'h0000_0000;
`ifdef DMEM_FWD_EN
        if (mem_read_i && in_range_s) begin
            mem_data_o = hit_s ? hit_data_s : ram_rdata_s;
        end else begin
            mem_data_o = 32'h0000_0000;
        end
`else
        if (mem_read_i && in_range_s && !hit_s) begin
            mem_data_o = ram_rdata_s;
        end else begin
            mem_data_o = 32'h0000_0000;
        end
`endif
    end

    assign wb_empty_o = (count_q == CNT_ZERO) && (state_q == ST_IDLE);
    assign err_o      = err_q;

    // FIFO bookkeeping, drain FSM next state and sticky error flag.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        head_d    = head_q;
        tail_d    = tail_q;
        buf_idx_d = buf_idx_q;
        buf_dat_d = buf_dat_q;
        err_d     = err_q | (!in_range_s && (mem_read_i || mem_write_i));

        if (push_s) begin
            buf_idx_d[tail_q] = word_idx_s;
            buf_dat_d[tail_q] = mem_data_i;
            tail_d            = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

        case (state_q)
            ST_IDLE: begin
                lat_cnt_d = LAT_ZERO;
                if (count_q != CNT_ZERO) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (commit_s) begin
                    // count_d already includes a store enqueued on this same edge.
                    lat_cnt_d = LAT_ZERO;
                    if (count_d != CNT_ZERO) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    state_d   = ST_BUSY;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                lat_cnt_d = LAT_ZERO;
            end
        endcase
    end

    // State registers; reset discards every pending store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= LAT_ZERO;
            head_q    <= {PTR_W{1'b0}};
            tail_q    <= {PTR_W{1'b0}};
            count_q   <= CNT_ZERO;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_idx_q[i] <= {ADDR_W{1'b0}};
                buf_dat_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
            buf_idx_q <= buf_idx_d;
            buf_dat_q <= buf_dat_d;
        end
    end

    // RAM write port. The FSM is forced to IDLE during reset, so no commit can occur then.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            ram_mem[buf_idx_q[head_q]] <= buf_dat_q[head_q];
        end
    end

endmodule
